// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings, flag bit
// positions inside the packed flag vector, and a small opcode classifier.
package alu_pkg;

  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  // Bit positions of the flags inside a packed {v,z,n,c} vector.
  localparam int FLAG_C    = 0;
  localparam int FLAG_N    = 1;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_V    = 3;
  localparam int NUM_FLAGS = 4;

  // True for the opcodes that go through the adder and produce c/v.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath used by the second pipeline stage.
// Ports:
//   a, b    : operands (WIDTH bits)
//   op      : 3-bit opcode (see alu_pkg)
//   result  : operation result, modulo 2^WIDTH
//   c,n,z,v : carry / negative / zero / signed-overflow flags of result
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v
);

  logic             w_is_sub;
  logic             w_is_arith;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;

  assign w_is_sub   = (op == OP_SUB);
  assign w_is_arith = is_arith(op);

  // Subtraction reuses the adder as A + ~B + 1, so carry=1 means no borrow.
  assign w_b_eff = w_is_sub ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};

  // Result multiplexer over the eight opcodes.
  always_comb begin
    result = {WIDTH{1'b0}};
    case (op)
      OP_NOTA: result = ~a;
      OP_NOTB: result = ~b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_ADD:  result = w_sum[WIDTH-1:0];
      OP_SUB:  result = w_sum[WIDTH-1:0];
      default: result = {WIDTH{1'b0}};
    endcase
  end

  assign n = result[WIDTH-1];
  assign z = (result == {WIDTH{1'b0}});
  assign c = w_is_arith & w_sum[WIDTH];
  // Overflow: both adder inputs share a sign that the sum does not.
  assign v = w_is_arith & (a[WIDTH-1] == w_b_eff[WIDTH-1]) & (w_sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides,
// accumulator-chained operand A and sticky carry/overflow flags.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand beat handshake (in_a, in_b, in_op, in_acc_sel)
//   out_valid/out_ready  : result beat handshake (out_result, out_c/n/z/v)
//   sticky_c, sticky_v   : OR of delivered c / v since the last clr_sticky
//   clr_sticky           : synchronous clear of the sticky flags (wins over a handshake)
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_c,
  output logic             out_n,
  output logic             out_z,
  output logic             out_v,
  output logic             sticky_c,
  output logic             sticky_v,
  input  logic             clr_sticky
);

  logic                 r_s1_valid;
  logic [WIDTH-1:0]     r_s1_a;
  logic [WIDTH-1:0]     r_s1_b;
  logic [2:0]           r_s1_op;
  logic                 r_s1_acc_sel;

  logic                 r_s2_valid;
  logic [WIDTH-1:0]     r_result;
  logic [NUM_FLAGS-1:0] r_flags;
  logic [WIDTH-1:0]     r_acc;
  logic                 r_sticky_c;
  logic                 r_sticky_v;

  logic                 w_s2_adv;
  logic                 w_in_hs;
  logic                 w_out_hs;
  logic [WIDTH-1:0]     w_core_a;
  logic [WIDTH-1:0]     w_core_result;
  logic [NUM_FLAGS-1:0] w_core_flags;

  assign w_s2_adv = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready = !r_s1_valid || w_s2_adv;
  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = r_s2_valid && out_ready;

  // The accumulator is written on the same edge the preceding beat leaves S1,
  // so a back-to-back chained beat already sees the fresh value here.
  assign w_core_a = r_s1_acc_sel ? r_acc : r_s1_a;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (w_core_a),
    .b      (r_s1_b),
    .op     (r_s1_op),
    .result (w_core_result),
    .c      (w_core_flags[FLAG_C]),
    .n      (w_core_flags[FLAG_N]),
    .z      (w_core_flags[FLAG_Z]),
    .v      (w_core_flags[FLAG_V])
  );

  // Stage 1: capture operand beat on input handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_a       <= {WIDTH{1'b0}};
      r_s1_b       <= {WIDTH{1'b0}};
      r_s1_op      <= 3'b000;
      r_s1_acc_sel <= 1'b0;
    end else if (w_in_hs) begin
      r_s1_valid   <= 1'b1;
      r_s1_a       <= in_a;
      r_s1_b       <= in_b;
      r_s1_op      <= in_op;
      r_s1_acc_sel <= in_acc_sel;
    end else if (w_s2_adv) begin
      r_s1_valid   <= 1'b0;
    end
  end

  // Stage 2: register result, flags and accumulator; hold while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= {WIDTH{1'b0}};
      r_flags    <= {NUM_FLAGS{1'b0}};
      r_acc      <= {WIDTH{1'b0}};
    end else if (w_s2_adv) begin
      r_s2_valid <= 1'b1;
      r_result   <= w_core_result;
      r_flags    <= w_core_flags;
      r_acc      <= w_core_result;
    end else if (w_out_hs) begin
      r_s2_valid <= 1'b0;
    end
  end

  // Sticky flags: accumulate delivered c/v; a clear on the same edge wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sticky_c <= 1'b0;
      r_sticky_v <= 1'b0;
    end else if (clr_sticky) begin
      r_sticky_c <= 1'b0;
      r_sticky_v <= 1'b0;
    end else if (w_out_hs) begin
      r_sticky_c <= r_sticky_c | r_flags[FLAG_C];
      r_sticky_v <= r_sticky_v | r_flags[FLAG_V];
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_result;
  assign out_c      = r_flags[FLAG_C];
  assign out_n      = r_flags[FLAG_N];
  assign out_z      = r_flags[FLAG_Z];
  assign out_v      = r_flags[FLAG_V];
  assign sticky_c   = r_sticky_c;
  assign sticky_v   = r_sticky_v;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: one WIDTH=4 and one WIDTH=32 instance share
// clock and reset. Stimulus tasks push hand-computed expectations into a
// queue per instance; a monitor per instance pops and compares on every
// output handshake.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        c, n, z, v;
    bit          lat;
    int          stamp;
  } exp_t;

  exp_t q4[$];
  exp_t q32[$];
  exp_t m4_e;
  exp_t m32_e;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic clk = 1'b0;
  logic reset_n;

  logic        in_valid4, in_ready4, in_acc_sel4, out_valid4, out_ready4;
  logic [3:0]  in_a4, in_b4, out_result4;
  logic [2:0]  in_op4;
  logic        out_c4, out_n4, out_z4, out_v4, sticky_c4, sticky_v4, clr_sticky4;

  logic        in_valid32, in_ready32, in_acc_sel32, out_valid32, out_ready32;
  logic [31:0] in_a32, in_b32, out_result32;
  logic [2:0]  in_op32;
  logic        out_c32, out_n32, out_z32, out_v32, sticky_c32, sticky_v32, clr_sticky32;

  alu_pipe #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4),
    .in_op(in_op4), .in_acc_sel(in_acc_sel4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_result(out_result4),
    .out_c(out_c4), .out_n(out_n4), .out_z(out_z4), .out_v(out_v4),
    .sticky_c(sticky_c4), .sticky_v(sticky_v4), .clr_sticky(clr_sticky4)
  );

  alu_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_a(in_a32), .in_b(in_b32),
    .in_op(in_op32), .in_acc_sel(in_acc_sel32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_result(out_result32),
    .out_c(out_c32), .out_n(out_n32), .out_z(out_z32), .out_v(out_v32),
    .sticky_c(sticky_c32), .sticky_v(sticky_v32), .clr_sticky(clr_sticky32)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (reset_n && out_valid4 && out_ready4) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL w4_unexpected: got beat %h with no expectation", out_result4);
      end else begin
        m4_e = q4.pop_front();
        if ({out_result4, out_c4, out_n4, out_z4, out_v4} !==
            {m4_e.res[3:0], m4_e.c, m4_e.n, m4_e.z, m4_e.v}) begin
          errors++;
          $display("FAIL w4_beat: got res=%h cnzv=%b%b%b%b, expected res=%h cnzv=%b%b%b%b",
                   out_result4, out_c4, out_n4, out_z4, out_v4,
                   m4_e.res[3:0], m4_e.c, m4_e.n, m4_e.z, m4_e.v);
        end
        if (m4_e.lat) begin
          checks++;
          if (cyc - m4_e.stamp != 2) begin
            errors++;
            $display("FAIL w4_latency: got %0d cycles, expected 2", cyc - m4_e.stamp);
          end
        end
      end
    end
  end

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin
    if (reset_n && out_valid32 && out_ready32) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL w32_unexpected: got beat %h with no expectation", out_result32);
      end else begin
        m32_e = q32.pop_front();
        if ({out_result32, out_c32, out_n32, out_z32, out_v32} !==
            {m32_e.res, m32_e.c, m32_e.n, m32_e.z, m32_e.v}) begin
          errors++;
          $display("FAIL w32_beat: got res=%h cnzv=%b%b%b%b, expected res=%h cnzv=%b%b%b%b",
                   out_result32, out_c32, out_n32, out_z32, out_v32,
                   m32_e.res, m32_e.c, m32_e.n, m32_e.z, m32_e.v);
        end
        if (m32_e.lat) begin
          checks++;
          if (cyc - m32_e.stamp != 2) begin
            errors++;
            $display("FAIL w32_latency: got %0d cycles, expected 2", cyc - m32_e.stamp);
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic acc, input logic [3:0] r,
                        input logic c, input logic n, input logic z, input logic v, input bit lat);
    exp_t e;
    int tries = 0;
    in_a4 = a; in_b4 = b; in_op4 = op; in_acc_sel4 = acc; in_valid4 = 1'b1;
    #1;
    while (!in_ready4 && tries < 50) begin
      @(posedge clk); #2;
      tries++;
    end
    if (!in_ready4) begin
      checks++; errors++;
      $display("FAIL w4_accept_timeout: in_ready=%b, expected 1", in_ready4);
    end else begin
      e.res = {28'h0, r}; e.c = c; e.n = n; e.z = z; e.v = v; e.lat = lat; e.stamp = cyc;
      q4.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic acc, input logic [31:0] r,
                         input logic c, input logic n, input logic z, input logic v, input bit lat);
    exp_t e;
    int tries = 0;
    in_a32 = a; in_b32 = b; in_op32 = op; in_acc_sel32 = acc; in_valid32 = 1'b1;
    #1;
    while (!in_ready32 && tries < 50) begin
      @(posedge clk); #2;
      tries++;
    end
    if (!in_ready32) begin
      checks++; errors++;
      $display("FAIL w32_accept_timeout: in_ready=%b, expected 1", in_ready32);
    end else begin
      e.res = r; e.c = c; e.n = n; e.z = z; e.v = v; e.lat = lat; e.stamp = cyc;
      q32.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid4 = 1'b0; in_valid32 = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid4 = 1'b0; in_a4 = 4'h0; in_b4 = 4'h0; in_op4 = 3'b000; in_acc_sel4 = 1'b0;
    out_ready4 = 1'b1; clr_sticky4 = 1'b0;
    in_valid32 = 1'b0; in_a32 = 32'h0; in_b32 = 32'h0; in_op32 = 3'b000; in_acc_sel32 = 1'b0;
    out_ready32 = 1'b1; clr_sticky32 = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid32}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready32}, 32'h1);
    chk("rst_out_result", out_result32, 32'h0);
    chk("rst_flags", {28'h0, out_c4, out_n4, out_z4, out_v4}, 32'h0);
    chk("rst_sticky", {30'h0, sticky_c32, sticky_v32}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // WIDTH=4 add / sub / logic, back-to-back with latency checks.
    issue4(4'hF, 4'hF, OP_ADD,  1'b0, 4'hE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    issue4(4'h7, 4'h7, OP_ADD,  1'b0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    issue4(4'h0, 4'h0, OP_ADD,  1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    issue4(4'h5, 4'h7, OP_SUB,  1'b0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    issue4(4'hA, 4'hA, OP_SUB,  1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    issue4(4'h7, 4'h9, OP_SUB,  1'b0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    issue4(4'h3, 4'h5, OP_XOR,  1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue4(4'h3, 4'h5, OP_XNOR, 1'b0, 4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    issue4(4'hC, 4'h0, OP_NOTA, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue4(4'hF, 4'h6, OP_NOTB, 1'b0, 4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    issue4(4'hC, 4'hA, OP_AND,  1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    issue4(4'h3, 4'h4, OP_OR,   1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);

    // Sticky: clear, then overflow persists across clean ops.
    clr_sticky4 = 1'b1;
    @(posedge clk); #1;
    clr_sticky4 = 1'b0;
    chk("sticky_cleared", {30'h0, sticky_c4, sticky_v4}, 32'h0);
    issue4(4'h7, 4'h7, OP_ADD, 1'b0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    issue4(4'h1, 4'h1, OP_ADD, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue4(4'h2, 4'h2, OP_ADD, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("sticky_v_persist", {31'h0, sticky_v4}, 32'h1);
    chk("sticky_c_clean", {31'h0, sticky_c4}, 32'h0);

    // Sticky: clear coincident with an overflowing output handshake.
    out_ready4 = 1'b0;
    issue4(4'h7, 4'h7, OP_ADD, 1'b0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("stall_out_valid4", {31'h0, out_valid4}, 32'h1);
    clr_sticky4 = 1'b1; out_ready4 = 1'b1;
    @(posedge clk); #1;
    clr_sticky4 = 1'b0;
    chk("sticky_clear_wins", {31'h0, sticky_v4}, 32'h0);
    idle(2);

    // WIDTH=32 backpressure.
    out_ready32 = 1'b0;
    issue32(32'd10, 32'd20, OP_ADD, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue32(32'd100, 32'd1, OP_SUB, 1'b0, 32'd99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    in_a32 = 32'hFFFF_FFFF; in_b32 = 32'h1; in_op32 = OP_ADD; in_acc_sel32 = 1'b0; in_valid32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready_low", {31'h0, in_ready32}, 32'h0);
      chk("bp_out_valid", {31'h0, out_valid32}, 32'h1);
      chk("bp_result_hold", out_result32, 32'd30);
      @(posedge clk); #1;
    end
    out_ready32 = 1'b1;
    issue32(32'hFFFF_FFFF, 32'h1, OP_ADD, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue32(32'h7FFF_FFFF, 32'h1, OP_ADD, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);

    // Accumulator chain on consecutive cycles; in_a is junk when chained.
    issue32(32'd5, 32'd3, OP_ADD, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue32(32'hDEAD_BEEF, 32'd2, OP_ADD, 1'b1, 32'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue32(32'hDEAD_BEEF, 32'd1, OP_SUB, 1'b1, 32'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);

    // Reset mid-stream with both stages full.
    out_ready32 = 1'b0;
    issue32(32'd1, 32'd1, OP_ADD, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue32(32'd3, 32'd3, OP_ADD, 1'b0, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_full", {30'h0, out_valid32, in_ready32}, 32'h2);
    in_valid32 = 1'b0;
    reset_n = 1'b0;
    #1;
    q32.delete();
    q4.delete();
    chk("midrst_out_valid", {31'h0, out_valid32}, 32'h0);
    chk("midrst_out_result", out_result32, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1; out_ready32 = 1'b1;
    #1;
    chk("postrst_in_ready", {31'h0, in_ready32}, 32'h1);
    // Chained beat proves the accumulator was cleared.
    issue32(32'h1234_5678, 32'd5, OP_ADD, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Bounded drain: every expected beat must have been delivered.
    for (int i = 0; i < 20 && (q4.size() != 0 || q32.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    chk("drain_pending", q4.size() + q32.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised two-stage pipelined ALU, next generation of the team's combinational 4-bit ALU.
- Keeps the same 3-bit opcode set and c/n/z/v flags, with these additions:
  - WIDTH generalisation
  - valid/ready handshakes on input and output, with backpressure
  - accumulator-chaining operand mode
  - sticky carry/overflow flags
- Sits between an operand sequencer and a result consumer in the datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (minimum 2).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept operand beat
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  3  opcode
- in_acc_sel  in  1  1 = replace A with the accumulator value
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  result
- out_c, out_n, out_z, out_v  out  1 each  flags of out_result
- sticky_c, sticky_v  out  1 each  OR of c / v over all results delivered since last clear
- clr_sticky  in  1  synchronous clear of sticky flags

Behaviour:
- Reset (async, reset_n=0):
  - stage valids, out_valid, out_result, all flags, sticky flags and accumulator all = 0.
  - in_ready = 1 after reset.
- Reset asserted mid-operation: in-flight beats are discarded; no partial output.
- Opcodes:
  - 000 ~A
  - 001 ~B
  - 010 A&B
  - 011 A|B
  - 100 A^B
  - 101 ~(A^B)
  - 110 A+B
  - 111 A-B, computed as A + ~B + 1
- Flags:
  - n = result[WIDTH-1]; z = (result == 0).
  - add/sub: c = carry out of bit WIDTH-1 (sub: c=1 means no borrow); v = signed overflow.
  - logic ops: c = 0, v = 0.
- Stage 1 (S1): registers in_a, in_b, in_op, in_acc_sel on an in_valid && in_ready handshake.
- Stage 2 (S2): computes from the S1 registers and registers result + flags; S2 holds the output beat.
- Advance rules:
  - s2_adv = S1 valid && (!S2 valid || out_ready).
  - in_ready = !S1 valid || s2_adv (combinational, no dependence on in_valid).
- Latency: 2 cycles from input handshake to out_valid when out_ready stays high.
  - Throughput 1 beat/cycle.
  - No bubbles inserted while out_ready=1.
- Backpressure: when out_valid && !out_ready, out_result and flags hold stable. S1 fills, then in_ready drops.
- Output beat ordering: strictly in acceptance order; no beat dropped or duplicated.
- Accumulator:
  - Loaded with the computed result on every s2_adv.
  - When in_acc_sel=1, operand A at compute time is the accumulator, i.e. the result of the immediately preceding accepted op. This holds even when that op is back-to-back, so no hazard stall is needed.
  - in_a is ignored when in_acc_sel=1.
  - Opcode 001 with acc_sel still ignores A.
- Sticky flags:
  - On each output handshake, sticky_c |= out_c and sticky_v |= out_v.
  - clr_sticky clears them next edge.
  - clr_sticky coincident with a handshake: clear wins, and that beat's flags are not accumulated.
- Width rules: all arithmetic is modulo 2^WIDTH; carry is taken from a WIDTH+1-bit sum.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_NOTA..OP_SUB (3'b000..3'b111)
  - flag bit index constants
- Sub-module alu_core:
  - combinational, parametrised by WIDTH
  - inputs a, b, op; outputs result, c, n, z, v
  - instantiated in S2.
- The pipeline, handshake, accumulator and sticky logic live in alu_pipe.

Test Plan:
- WIDTH=4, out_ready=1, back-to-back ops:
  - op 110 F+F -> E, c1 n1 z0 v0
  - op 110 7+7 -> E, c0 n1 v1
  - op 110 0+0 -> 0, z1
  - Each result appears exactly 2 cycles after its handshake.
- WIDTH=4 sub and logic:
  - op 111 5-7 -> E, c0 n1 v0
  - op 111 A-A -> 0, c1 z1
  - op 111 7-9 -> E, v1
  - op 100 3^5 -> 6; op 101 3,5 -> 9; op 000 A=C -> 3
  - All logic ops have c=v=0.
- Backpressure, WIDTH=32:
  - Drive 4 beats with out_ready=0 -> in_ready drops after 2 accepted.
  - out_result holds the first result stable.
  - Release out_ready -> results emerge in order with none lost.
- Accumulator chain, WIDTH=32:
  - Sequence: A=5 B=3 add, then acc_sel add B=2, then acc_sel sub B=1 -> 8, 10, 9.
  - Issued on consecutive cycles.
- Sticky:
  - 7+7 at WIDTH=4 sets sticky_v=1 and it persists across later clean ops.
  - clr_sticky coincident with an overflowing handshake -> sticky_v=0.
- Reset mid-stream:
  - Assert reset_n=0 with both stages valid -> out_valid=0 immediately, accumulator=0.
  - After release, in_ready=1 and the first new beat has the correct result.
